// File: rtl/integer_part_arbiter_if.sv
// ============================================================================
// Module   : integer_part_arbiter_if
// Desc     : Requester, shared-unit and flush signals of integer_part_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface integer_part_arbiter_if #(
  parameter int BITS = 16,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*BITS-1:0] req_a;
  logic [NREQ-1:0]      req_ready;
  logic                 unit_in_valid;
  logic [BITS-1:0]      unit_a;
  logic                 unit_out_valid;
  logic [BITS-1:0]      unit_c;
  logic [NREQ-1:0]      rsp_valid;
  logic [BITS-1:0]      rsp_c;
  logic                 flush;
  logic                 flush_done;

  modport master (
    input  req_valid, req_a, unit_out_valid, unit_c, flush,
    output req_ready, unit_in_valid, unit_a, rsp_valid, rsp_c, flush_done
  );

  modport slave (
    output req_valid, req_a, unit_out_valid, unit_c, flush,
    input  req_ready, unit_in_valid, unit_a, rsp_valid, rsp_c, flush_done
  );
endinterface

`default_nettype wire

// File: rtl/integer_part_arbiter.sv
// ============================================================================
// Module   : integer_part_arbiter
// Desc     : Round-robin sharing of one pipelined integer-part unit among NREQ
//            requesters; optional sticky err via INTEGER_PART_ARB_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module integer_part_arbiter #(
  parameter int BITS  = 16,
  parameter int NREQ  = 4,
  parameter int DEPTH = 4
) (
  input wire clk,
  input wire rst,
  integer_part_arbiter_if.master bus
`ifdef INTEGER_PART_ARB_ERR_EN
  ,
  output logic err
`endif
);

  localparam int PW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   last_ptr;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic [NREQ-1:0] grant;
  logic            found;
  logic [CW-1:0]   count;
  logic [PW-1:0]   tags [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [NREQ-1:0] rsp_onehot;
  logic            transfer;
  logic            pop;
  logic            empty;
  logic            full;
  logic            drain_done;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign pop        = bus.unit_out_valid & ~empty;
  assign transfer   = |grant;
  assign drain_done = (state == DRAIN) && empty && !bus.unit_in_valid;
  assign rsp_onehot = NREQ'(1) << tags[rd_ptr];
  assign bus.req_ready = grant;

  // Search starts one past the last winner; rst gates the grant so the
  // combinational ready drops the moment reset is applied.
  always_comb begin
    grant     = '0;
    grant_idx = last_ptr;
    found     = 1'b0;
    cand      = '0;
    if (state == RUN && !full && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = PW'((int'(last_ptr) + k) % NREQ);
        if (!found && bus.req_valid[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.flush) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= RUN;
      last_ptr          <= PW'(NREQ - 1);
      count             <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      bus.unit_in_valid <= 1'b0;
      bus.unit_a        <= '0;
      bus.rsp_valid     <= '0;
      bus.rsp_c         <= '0;
      bus.flush_done    <= 1'b0;
    end else begin
      state             <= state_nxt;
      bus.unit_in_valid <= transfer;
      bus.flush_done    <= drain_done;
      bus.rsp_valid     <= pop ? rsp_onehot : '0;
      if (transfer) begin
        last_ptr   <= grant_idx;
        bus.unit_a <= bus.req_a[int'(grant_idx)*BITS +: BITS];
        wr_ptr     <= wr_ptr + AW'(1);
      end
      if (pop) begin
        bus.rsp_c <= bus.unit_c;
        rd_ptr    <= rd_ptr + AW'(1);
      end
      if (transfer && !pop)
        count <= count + CW'(1);
      else if (!transfer && pop)
        count <= count - CW'(1);
    end
  end

  // Tag storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (transfer)
      tags[wr_ptr] <= grant_idx;
  end

`ifdef INTEGER_PART_ARB_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (bus.unit_out_valid && empty)
      err <= 1'b1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_integer_part_arbiter.sv
// ============================================================================
// Module   : tb_integer_part_arbiter
// Desc     : Self-checking bench with a half-float truncation unit model and
//            an issue-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_integer_part_arbiter;

  logic clk;
  logic rst;
`ifdef INTEGER_PART_ARB_ERR_EN
  logic err;
`endif

  integer_part_arbiter_if #(.BITS(16), .NREQ(4)) bus ();

  integer_part_arbiter #(.BITS(16), .NREQ(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef INTEGER_PART_ARB_ERR_EN
    ,
    .err (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a;
    logic [3:0]  ready;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] res;
    int          due;
  } sent_t;

  typedef struct {
    logic [15:0] res;
    int          due;
  } uent_t;

  sent_t       sb [$];
  uent_t       uq [$];
  vec_t        vecs [10];
  logic [3:0]  exp_rdy [6];
  int          cyc, nvec, nerr, fd_cnt, fd_cyc, g_cyc;
  logic        exp_issue, stall, inject, lat_chk;
  logic [15:0] exp_a;

  // Integer part of an IEEE half: clear the fraction bits below the binary point.
  function automatic logic [15:0] trunc_h(input logic [15:0] a);
    int e;
    logic [15:0] m;
    e = int'(a[14:10]);
    if (e < 15) return {a[15], 15'd0};
    if (e >= 25) return a;
    m = 16'hFFFF << (25 - e);
    return a & m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_lanes(input logic [15:0] a);
    for (int i = 0; i < 4; i++)
      bus.req_a[i*16 +: 16] = 16'(int'(a) + (i - 1) * 64);
  endtask

  task automatic step();
    sent_t s;
    uent_t u;
    logic [3:0] x;
    int gi;
    @(negedge clk);
    cyc++;
    if (bus.rsp_valid != 4'b0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
      end else begin
        s = sb.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(4'b1 << s.idx));
        chk("rsp_c", 32'(bus.rsp_c), 32'(s.res));
        if (lat_chk) chk("rsp_latency", 32'(cyc), 32'(s.due));
      end
    end else if (lat_chk && sb.size() != 0 && sb[0].due < cyc) begin
      chk("rsp_missing", 32'(cyc), 32'(sb[0].due));
      void'(sb.pop_front());
    end
    chk("issue_valid", 32'(bus.unit_in_valid), 32'(exp_issue));
    if (exp_issue) chk("unit_a", 32'(bus.unit_a), 32'(exp_a));
    x = bus.req_valid & bus.req_ready;
    exp_issue = 1'b0;
    if (x != 4'b0) begin
      gi = 0;
      for (int i = 3; i >= 0; i--) if (x[i]) gi = i;
      if (!$onehot(x)) chk("grant_onehot", 32'(x), 32'(4'b1 << gi));
      exp_issue = 1'b1;
      exp_a = bus.req_a[gi*16 +: 16];
      sb.push_back('{gi, trunc_h(exp_a), cyc + 5});
    end
    if (bus.unit_in_valid) uq.push_back('{trunc_h(bus.unit_a), cyc + 3});
    bus.unit_out_valid = inject;
    if (inject) begin
      bus.unit_c = 16'hDEAD;
    end else if (!stall && uq.size() != 0 && uq[0].due <= cyc) begin
      u = uq.pop_front();
      bus.unit_out_valid = 1'b1;
      bus.unit_c = u.res;
    end
    if (bus.flush_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_unit_in_valid", 32'(bus.unit_in_valid), 32'h0);
    chk("rst_unit_a", 32'(bus.unit_a), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_c", 32'(bus.rsp_c), 32'h0);
    chk("rst_flush_done", 32'(bus.flush_done), 32'h0);
    sb.delete();
    exp_issue = 1'b0;
    steps(2);
    rst = 1'b0;
  endtask

  initial begin
    cyc = 0; nvec = 0; nerr = 0; fd_cnt = 0; fd_cyc = -1;
    exp_issue = 1'b0; exp_a = '0; stall = 1'b0; inject = 1'b0; lat_chk = 1'b1;
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_a = '0;
    bus.unit_out_valid = 1'b0;
    bus.unit_c = '0;
    bus.flush = 1'b0;
    #1;
    do_reset();

    // Round-robin vectors from reset (pointer starts at 3), one idle cycle between.
    vecs[0] = '{4'b0001, 16'h3C00, 4'b0001};
    vecs[1] = '{4'b0000, 16'h0000, 4'b0000};
    vecs[2] = '{4'b1111, 16'h4500, 4'b0010};
    vecs[3] = '{4'b1111, 16'hC266, 4'b0100};
    vecs[4] = '{4'b0011, 16'h3800, 4'b0001};
    vecs[5] = '{4'b1001, 16'h5A4D, 4'b1000};
    vecs[6] = '{4'b1000, 16'h7C00, 4'b1000};
    vecs[7] = '{4'b0110, 16'h4E00, 4'b0010};
    vecs[8] = '{4'b0010, 16'h4248, 4'b0010};
    vecs[9] = '{4'b0101, 16'h4B33, 4'b0100};
    for (int v = 0; v < 10; v++) begin
      set_lanes(vecs[v].a);
      bus.req_valid = vecs[v].valid;
      #1;
      chk("rr_grant", 32'(bus.req_ready), 32'(vecs[v].ready));
      step();
      bus.req_valid = 4'b0;
      step();
    end
    steps(8);

    // All requesters held: 0,1,2,3, full for a cycle, then 0 again.
    do_reset();
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
    set_lanes(16'h4A00);
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      #1;
      chk("hold_all_grant", 32'(bus.req_ready), 32'(exp_rdy[j]));
      if (j == 5) bus.req_valid = 4'b0;
      step();
    end
    steps(8);

    // Stalled unit: exactly DEPTH grants, then ready low until a result pops.
    do_reset();
    lat_chk = 1'b0;
    stall = 1'b1;
    set_lanes(16'h4D12);
    bus.req_valid = 4'b0100;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk("stall_grant", 32'(bus.req_ready), (j < 4) ? 32'h4 : 32'h0);
      step();
    end
    stall = 1'b0;
    #1;
    chk("full_no_grant", 32'(bus.req_ready), 32'h0);
    step();
    #1;
    chk("grant_after_pop", 32'(bus.req_ready), 32'h4);
    bus.req_valid = 4'b0;
    steps(10);
    chk("stall_drained", 32'(sb.size()), 32'h0);
    lat_chk = 1'b1;

    // Flush with three ops in flight, the third granted in the flush cycle.
    do_reset();
    fd_cnt = 0;
    set_lanes(16'h4880);
    bus.req_valid = 4'b1111;
    #1; chk("pre_flush_grant0", 32'(bus.req_ready), 32'h1); step();
    #1; chk("pre_flush_grant1", 32'(bus.req_ready), 32'h2); step();
    #1; chk("pre_flush_grant2", 32'(bus.req_ready), 32'h4);
    bus.flush = 1'b1;
    step();
    g_cyc = cyc;
    bus.flush = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      #1;
      chk("drain_no_grant", 32'(bus.req_ready), 32'h0);
      if (j == 2) bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
    end
    #1;
    chk("grant_resumes", 32'(bus.req_ready), 32'h8);
    bus.req_valid = 4'b0;
    steps(2);
    chk("flush_done_count", 32'(fd_cnt), 32'h1);
    chk("flush_done_cycle", 32'(fd_cyc), 32'(g_cyc + 6));
    steps(6);

    // Result strobe with no tags outstanding.
    inject = 1'b1;
    step();
    inject = 1'b0;
    step();
    #1;
    chk("orphan_rsp_valid", 32'(bus.rsp_valid), 32'h0);
`ifdef INTEGER_PART_ARB_ERR_EN
    chk("err_set", 32'(err), 32'h1);
    steps(3);
    chk("err_sticky", 32'(err), 32'h1);
    do_reset();
    chk("err_cleared", 32'(err), 32'h0);
`endif

    // Asynchronous reset with two ops outstanding.
    set_lanes(16'h4321);
    bus.req_valid = 4'b0011;
    steps(2);
    bus.req_valid = 4'b0;
    step();
    do_reset();
    for (int j = 0; j < 6; j++) begin
      #1;
      chk("late_rsp_dropped", 32'(bus.rsp_valid), 32'h0);
      step();
    end
    bus.req_valid = 4'b1111;
    #1;
    chk("first_after_reset", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 4'b0;
    steps(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/integer_part_arbiter.md
INTEGER_PART_ARBITER -- requirements
Module: integer_part_arbiter

Interface
REQ-001 Parameter BITS, default 16, operand/result width of the shared integer-part unit.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter DEPTH, default 4, maximum outstanding operations in the shared unit (power of two, 2..16).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester operation request.
REQ-007 req_a  input  NREQ*BITS  operands, requester i at bits [i*BITS +: BITS].
REQ-008 req_ready  output  NREQ  one-hot grant, combinational.
REQ-009 unit_in_valid  output  1  issue strobe to shared unit.
REQ-010 unit_a  output  BITS  operand to shared unit.
REQ-011 unit_out_valid  input  1  result strobe from shared unit.
REQ-012 unit_c  input  BITS  result from shared unit.
REQ-013 rsp_valid  output  NREQ  one-hot result strobe to owning requester.
REQ-014 rsp_c  output  BITS  result, shared bus.
REQ-015 flush  input  1  request drain of outstanding work.
REQ-016 flush_done  output  1  one-cycle pulse, drain complete.

Function
REQ-017 States RUN and DRAIN; grants SHALL occur only in RUN.
REQ-018 In RUN with outstanding count < DEPTH, the block SHALL assert req_ready for exactly one valid requester, chosen round-robin starting at (last granted + 1) mod NREQ.
REQ-019 Transfer occurs when req_valid[i] & req_ready[i]; next cycle unit_in_valid=1 and unit_a=req_a of requester i (registered, 1-cycle issue latency).
REQ-020 On transfer, index i SHALL be pushed into an in-order tag FIFO of DEPTH entries and the last-granted pointer updated to i.
REQ-021 On unit_out_valid with tag FIFO non-empty, the head tag SHALL be popped and, next cycle, rsp_valid[tag]=1 and rsp_c=unit_c (registered).
REQ-022 End-to-end latency SHALL be 1 + unit latency + 1 cycles; results returned strictly in issue order.
REQ-023 Outstanding count increments on transfer, decrements on pop, unchanged when both occur in one cycle.
REQ-024 Full (count == DEPTH): no grant, even if a pop occurs the same cycle.
REQ-025 unit_out_valid with empty tag FIFO SHALL be ignored: no rsp_valid, no state change (except REQ-042).
REQ-026 No valid requests: req_ready=0, pointer unchanged, unit_in_valid=0 next cycle.
REQ-027 flush in RUN: transition to DRAIN next cycle; a grant in the same cycle as flush SHALL still complete.
REQ-028 In DRAIN, when count == 0 and no issue is pending, return to RUN and pulse flush_done for one cycle.
REQ-029 flush asserted in DRAIN SHALL be ignored.
REQ-030 rsp_valid and unit_in_valid SHALL each be single-cycle per operation; unit_a/rsp_c SHALL hold last value when their strobes are low.

Reset
REQ-031 rst asserted SHALL immediately clear: req_ready, unit_in_valid, unit_a, rsp_valid, rsp_c, flush_done to 0.
REQ-032 Reset SHALL empty the tag FIFO, clear the count, set state RUN, set last-granted pointer to NREQ-1 (requester 0 wins first).
REQ-033 Reset mid-operation SHALL discard in-flight tags; results arriving afterwards fall under REQ-025.

Configuration
REQ-040 Macro INTEGER_PART_ARB_ERR_EN SHALL control an error-detection feature.
REQ-041 Without the macro: no err port; REQ-025 events are silently dropped.
REQ-042 With the macro: output err (1 bit) SHALL be set sticky on unit_out_valid with empty tag FIFO, cleared only by rst.

Verification
REQ-050 Reset, all req_valid=4'b1111 held, unit latency 3 -> grants in order 0,1,2,3,0; rsp_valid returns same order 5 cycles after each grant.
REQ-051 DEPTH=4, unit stalled (no unit_out_valid), req_valid[2]=1 held -> exactly 4 grants, then req_ready=0 until a result returns.
REQ-052 Only req 1 valid, a=16'h4248 (3.14 half) -> rsp_valid=4'b0010, rsp_c equals unit_c (16'h4200).
REQ-053 Three ops in flight, pulse flush -> no further grants, flush_done pulses one cycle after third rsp_valid, grants resume.
REQ-054 unit_out_valid with empty FIFO -> rsp_valid stays 0; with INTEGER_PART_ARB_ERR_EN err=1 until rst.
REQ-055 rst asserted with two ops outstanding -> all outputs 0 asynchronously; late results produce no rsp_valid; next grant is requester 0.
